vram_tile_arbiter: RTL and testbench



---
 rtl/vram_tile_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_tile_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_tile_arbiter.sv
// Shares a single-port synchronous-read VRAM between tile-map prefetch for the
// 80x60 tile display and a req/ack CPU port; video slots always win.
module vram_tile_arbiter #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] TILE_BASE = 16'hE000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tile_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } cpu_state_t;

    cpu_state_t state, state_nx;

    logic [9:0]        v_next;
    logic [9:0]        h_plus;
    logic              vis_slot;
    logic              pre_slot;
    logic              video_slot;
    logic [6:0]        row;
    logic [6:0]        col;
    logic [12:0]       tile_off;
    logic [ADDR_W-1:0] video_addr;
    logic              cpu_go;
    logic              cpu_issue;
    logic              cpu_rd;
    logic              vid_issue;
    logic              vid_data;

    // Fetch for the tile starting 3 pixels later; at the end of the line
    // prefetch column 0 of the next line.
    always_comb begin
        v_next     = (vCount == 10'd524) ? 10'd0 : vCount + 10'd1;
        h_plus     = hCount + 10'd3;
        vis_slot   = (hCount[2:0] == 3'd5) && (hCount <= 10'd629) && (vCount < 10'd480);
        pre_slot   = (hCount == 10'd797) && (v_next < 10'd480);
        video_slot = vis_slot || pre_slot;
        row        = pre_slot ? v_next[9:3] : vCount[9:3];
        col        = pre_slot ? 7'd0 : 7'(h_plus >> 3);
        tile_off   = {row, 6'b0} + {2'b0, row, 4'b0} + {6'b0, col};
        video_addr = TILE_BASE + ADDR_W'(tile_off);
        cpu_go     = (state == ST_IDLE) && cpu_req && !video_slot;
    end

    // WAIT spans the issue cycle and the data cycle; cpu_issue tells them apart.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cpu_go) state_nx = ST_WAIT;
            ST_WAIT: if (!cpu_issue) state_nx = ST_ACK;
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign cpu_ack = (state == ST_ACK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cpu_issue <= 1'b0;
            cpu_rd    <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nx;
            cpu_issue <= cpu_go;
            if (cpu_go) cpu_rd <= !cpu_we;
            if ((state == ST_WAIT) && !cpu_issue && cpu_rd) cpu_rdata <= mem_rdata;
        end
    end

    // Registered VRAM port: video, else CPU, else an idle read of the last address.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (video_slot) begin
            mem_addr <= video_addr;
            mem_we   <= 1'b0;
        end else if (cpu_go) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_wdata;
        end else begin
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vid_issue <= 1'b0;
            vid_data  <= 1'b0;
            tile_idx  <= '0;
        end else begin
            vid_issue <= video_slot;
            vid_data  <= vid_issue;
            if (vid_data) tile_idx <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_tile_arbiter.sv
// Bench for vram_tile_arbiter: directed video/CPU/reset scenarios followed by a
// partial frame with random CPU traffic, all scored against a behavioural model.
module tb_vram_tile_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] tile_idx;

    always #5 clock = ~clock;

    vram_tile_arbiter #(.ADDR_W(16), .DATA_W(16), .TILE_BASE(16'hE000)) dut (
        .clock(clock), .reset(reset), .hCount(hCount), .vCount(vCount),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .tile_idx(tile_idx)
    );

    // VRAM: initial contents come from tmap/lo_init, later writes from wmem.
    logic [15:0] tmap    [0:4799];
    logic [15:0] lo_init [0:4095];
    logic [15:0] wmem    [0:65535];
    bit          wvalid  [0:65535];

    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a >= 16'hE000 && a < 16'hF2C0) return tmap[int'(a) - 'hE000];
        if (a < 16'h1000) return lo_init[a[11:0]];
        return 16'h0000;
    endfunction

    always @(posedge clock) begin
        if (mem_we) begin
            wmem[mem_addr]   <= mem_wdata;
            wvalid[mem_addr] <= 1'b1;
        end
        mem_rdata <= wvalid[mem_addr] ? wmem[mem_addr] : init_word(mem_addr);
    end

    // Scoreboard and reference model state
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ref_mem [0:4095];
    bit          mon_en = 1'b0;
    bit          chk_tiles = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    int          m_issue_cyc = -10;
    int          m_ack_cyc = -10;
    logic [15:0] exp_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d h=%0d v=%0d)",
                     tag, got, exp, cyc, hCount, vCount);
        end
    endtask

    function automatic bit is_vslot(input int h, input int v);
        int vn;
        vn = (v == 524) ? 0 : v + 1;
        return (h % 8 == 5) && ((h <= 629 && v < 480) || (h == 797 && vn < 480));
    endfunction

    function automatic logic [15:0] vaddr(input int h, input int v);
        int vn, row, col;
        vn = (v == 524) ? 0 : v + 1;
        if (h == 797) begin
            row = vn / 8;
            col = 0;
        end else begin
            row = v / 8;
            col = (h + 3) / 8;
        end
        return 16'(32'hE000 + row * 80 + col);
    endfunction

    task automatic set_pos(input int h, input int v);
        hCount = 10'(h);
        vCount = 10'(v);
    endtask

    // One clock: advance the raster, update the model for the edge just taken,
    // then score the outputs of the new cycle.
    task automatic step();
        int hp, vp, p, ti;
        bit rp, rstp, vs, iss, ackc;
        hp   = int'(hCount);
        vp   = int'(vCount);
        rp   = cpu_req;
        rstp = reset;
        p    = cyc;
        vs   = is_vslot(hp, vp);
        @(posedge clock);
        #1;
        cyc++;
        if (hCount == 10'd799) begin
            hCount = 10'd0;
            vCount = (vCount == 10'd524) ? 10'd0 : vCount + 10'd1;
        end else begin
            hCount = hCount + 10'd1;
        end

        if (rstp) begin
            m_busy    = 1'b0;
            exp_rdata = '0;
            exp_q.delete();
        end else begin
            if (!m_busy && rp && !vs) begin
                m_busy      = 1'b1;
                m_issue_cyc = p + 1;
                m_ack_cyc   = p + 3;
                m_we        = cpu_we;
                m_addr      = cpu_addr;
                m_wdata     = cpu_wdata;
                if (cpu_we) ref_mem[cpu_addr[11:0]] = cpu_wdata;
                else exp_q.push_back(ref_mem[cpu_addr[11:0]]);
            end else if (m_busy && p == m_ack_cyc) begin
                m_busy = 1'b0;
            end
        end

        if (mon_en) begin
            iss  = m_busy && (cyc == m_issue_cyc);
            ackc = m_busy && (cyc == m_ack_cyc);
            check("mem_we", 32'(mem_we), 32'(iss && m_we));
            if (iss) begin
                check("cpu_issue_addr", 32'(mem_addr), 32'(m_addr));
                if (m_we) check("cpu_issue_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            if (vs && !rstp) check("video_addr", 32'(mem_addr), 32'(vaddr(hp, vp)));
            check("cpu_ack", 32'(cpu_ack), 32'(ackc));
            if (ackc && !m_we && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
            check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
            if (chk_tiles && vCount < 10'd480 && hCount < 10'd640 && hCount[2:0] == 3'd0) begin
                ti = (int'(vCount) / 8) * 80 + int'(hCount) / 8;
                check("tile_idx", 32'(tile_idx), 32'(tmap[ti]));
            end
        end
    endtask

    task automatic new_req();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 4095));
        cpu_wdata = 16'($urandom);
    endtask

    initial begin
        int  acks;
        bit  ack_seen;
        for (int i = 0; i < 4800; i++) tmap[i] = 16'($urandom);
        tmap[165] = 16'h1234;
        for (int i = 0; i < 4096; i++) lo_init[i] = 16'($urandom);
        lo_init[12'h040] = 16'hBEEF;
        for (int i = 0; i < 4096; i++) ref_mem[i] = lo_init[i];

        // Reset values
        reset = 1'b1;
        step();
        step();
        mon_en = 1'b1;
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_tile_idx", 32'(tile_idx), 32'h0);
        step();
        reset = 1'b0;
        step();

        // Visible-line tile fetch
        set_pos(36, 18);
        step();
        step();
        check("vf_addr", 32'(mem_addr), 32'hE0A5);
        check("vf_we", 32'(mem_we), 32'h0);
        step();
        step();
        check("vf_tile", 32'(tile_idx), 32'h1234);

        // End-of-line prefetch
        set_pos(796, 524);
        step();
        step();
        check("pf_addr_line0", 32'(mem_addr), 32'hE000);
        step();
        step();
        check("pf_pos", 32'({hCount, vCount}), 32'h0);
        check("pf_tile_line0", 32'(tile_idx), 32'(tmap[0]));
        set_pos(796, 7);
        step();
        step();
        check("pf_addr_row1", 32'(mem_addr), 32'hE050);

        // CPU read during vertical blanking
        set_pos(100, 500);
        cpu_we = 1'b0;
        cpu_addr = 16'h0040;
        cpu_wdata = 16'h0000;
        cpu_req = 1'b1;
        step();
        check("blank_issue_addr", 32'(mem_addr), 32'h0040);
        check("blank_issue_ack", 32'(cpu_ack), 32'h0);
        step();
        check("blank_wait_ack", 32'(cpu_ack), 32'h0);
        step();
        check("blank_ack", 32'(cpu_ack), 32'h1);
        check("blank_rdata", 32'(cpu_rdata), 32'hBEEF);
        step();
        cpu_req = 1'b0;
        check("blank_ack_width", 32'(cpu_ack), 32'h0);
        step();

        // CPU write first sampled on a video decision edge
        set_pos(13, 0);
        cpu_we = 1'b1;
        cpu_addr = 16'h0010;
        cpu_wdata = 16'h5A5A;
        cpu_req = 1'b1;
        step();
        check("conf_vid_addr", 32'(mem_addr), 32'hE002);
        check("conf_vid_we", 32'(mem_we), 32'h0);
        step();
        check("conf_cpu_we", 32'(mem_we), 32'h1);
        check("conf_cpu_addr", 32'(mem_addr), 32'h0010);
        check("conf_cpu_wdata", 32'(mem_wdata), 32'h5A5A);
        step();
        check("conf_tile", 32'(tile_idx), 32'(tmap[2]));
        check("conf_early_ack", 32'(cpu_ack), 32'h0);
        step();
        check("conf_ack_at_4", 32'(cpu_ack), 32'h1);
        step();
        cpu_req = 1'b0;
        step();
        check("conf_vram_written", 32'(wmem[16'h0010]), 32'h5A5A);

        // Reset asserted in the first WAIT cycle of a read
        set_pos(200, 500);
        cpu_we = 1'b0;
        cpu_addr = 16'h0040;
        cpu_req = 1'b1;
        step();
        reset = 1'b1;
        cpu_req = 1'b0;
        step();
        check("rw_mem_addr", 32'(mem_addr), 32'h0);
        check("rw_mem_we", 32'(mem_we), 32'h0);
        check("rw_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rw_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rw_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rw_tile_idx", 32'(tile_idx), 32'h0);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_ack) acks++;
        end
        check("rw_no_ack", 32'(acks), 32'h0);

        // Frame from the vertical-blank prefetch through 40 visible lines
        set_pos(0, 522);
        chk_tiles = 1'b1;
        ack_seen = 1'b0;
        for (int k = 0; k < 800 * 44; k++) begin
            if (vCount == 10'd40 && hCount == 10'd0) break;
            step();
            if (ack_seen) begin
                ack_seen = 1'b0;
                if ($urandom_range(0, 3) != 0) new_req();
                else cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                new_req();
            end
            if (cpu_ack) ack_seen = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack_seen) begin
                cpu_req = 1'b0;
                ack_seen = 1'b0;
            end
            if (cpu_ack) ack_seen = 1'b1;
        end
        check("drain_exp_q", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
